// File: rtl/i2c_tx_fifo.sv
// i2c_tx_fifo: synchronous TX FIFO between the APB slave bridge and the I2C core.
// Buffers DATA_W-bit words written by the bridge until the core pops them.
// Status flags are combinational decodes of the registered occupancy count.
// OVERFLOW/UNDERFLOW are sticky until ERR_CLR or reset.
// Optional build macro I2C_TX_FIFO_FWFT_EN selects first-word-fall-through reads.
// Without it, RD_DATA is registered and arrives one cycle after an accepted read.
module i2c_tx_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       WR_EN,
  input  logic [DATA_W-1:0]          WR_DATA,
  input  logic                       RD_EN,
  output logic [DATA_W-1:0]          RD_DATA,
  input  logic                       ERR_CLR,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       ALMOST_FULL,
  output logic                       ALMOST_EMPTY,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Storage array; never reset, so stale words survive a reset but are unreachable.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Control state.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ovf_q,    ovf_d;
  logic             unf_q,    unf_d;

  // Handshake decisions for the current cycle.
  logic full, empty;
  logic rd_acc, wr_acc;

  // Occupancy decodes; all flags derive from the registered count.
  always_comb begin
    full         = (count_q == DEPTH_CNT);
    empty        = (count_q == '0);
    ALMOST_FULL  = (count_q >= AF_CNT);
    ALMOST_EMPTY = (count_q <= AE_CNT);
  end

  assign FULL      = full;
  assign EMPTY     = empty;
  assign COUNT     = count_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;

  // Accept logic: a read frees a slot, so a write is accepted when full if a read is too.
  always_comb begin
    rd_acc = RD_EN & ~empty;
    wr_acc = WR_EN & (~full | rd_acc);
  end

  // Next-state for pointers, count and sticky errors (new error beats ERR_CLR).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q & ~ERR_CLR;
    unf_d    = unf_q & ~ERR_CLR;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (WR_EN & full & ~rd_acc) begin
      ovf_d = 1'b1;
    end
    if (RD_EN & empty) begin
      unf_d = 1'b1;
    end
  end

  // Control registers; reset overrides any strobe on the same edge.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Memory write port; suppressed while reset is asserted.
  always_ff @(posedge PCLK) begin
    if (!PRESET && wr_acc) begin
      mem_q[wr_ptr_q] <= WR_DATA;
    end
  end

`ifdef I2C_TX_FIFO_FWFT_EN
  // Head word falls through combinationally; forced to zero when nothing is stored.
  always_comb begin
    RD_DATA = '0;
    if (!empty) begin
      RD_DATA = mem_q[rd_ptr_q];
    end
  end
`else
  logic [DATA_W-1:0] rd_data_q;

  // Registered read port; holds the last word until another read is accepted.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rd_data_q <= '0;
    end else if (rd_acc) begin
      rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  assign RD_DATA = rd_data_q;
`endif

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// tb_i2c_tx_fifo: directed self-checking bench for i2c_tx_fifo (DEPTH=16, AF=12, AE=2).
module tb_i2c_tx_fifo;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        WR_EN;
  logic [31:0] WR_DATA;
  logic        RD_EN;
  logic [31:0] RD_DATA;
  logic        ERR_CLR;
  logic        FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY;
  logic [4:0]  COUNT;
  logic        OVERFLOW, UNDERFLOW;

  int n_checks = 0;
  int n_fail   = 0;

  i2c_tx_fifo #(.DATA_W(32), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
    .RD_EN(RD_EN), .RD_DATA(RD_DATA), .ERR_CLR(ERR_CLR),
    .FULL(FULL), .EMPTY(EMPTY), .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
    .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle();
    WR_EN = 1'b0; RD_EN = 1'b0; ERR_CLR = 1'b0; PRESET = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    WR_EN = 1'b1; WR_DATA = d;
    tick();
    WR_EN = 1'b0;
  endtask

  // Pop one word and check it in whichever read mode the DUT was built with.
  task automatic pop(input string tag, input logic [31:0] exp);
    RD_EN = 1'b1;
`ifdef I2C_TX_FIFO_FWFT_EN
    chk(tag, RD_DATA, exp);
    tick();
`else
    tick();
    chk(tag, RD_DATA, exp);
`endif
    RD_EN = 1'b0;
  endtask

  initial begin
    idle();
    WR_DATA = 32'h0;

    // Reset with a write strobe held high: nothing may be stored.
    PRESET = 1'b1; WR_EN = 1'b1; WR_DATA = 32'hDEADBEEF;
    tick(); tick();
    chk("rst_count", 32'(COUNT), 32'd0);
    chk("rst_empty", 32'(EMPTY), 32'd1);
    chk("rst_full",  32'(FULL),  32'd0);
    chk("rst_ae",    32'(ALMOST_EMPTY), 32'd1);
    chk("rst_af",    32'(ALMOST_FULL),  32'd0);
    chk("rst_rdata", RD_DATA, 32'h0);
    chk("rst_ovf",   32'(OVERFLOW), 32'd0);
    idle();
    tick();
    chk("post_rst_count", 32'(COUNT), 32'd0);

    // Fill with 1..16 and watch the threshold flags.
    for (int i = 1; i <= 16; i++) begin
      push(32'(i));
      chk("fill_count", 32'(COUNT), 32'(i));
      chk("fill_af",    32'(ALMOST_FULL),  32'(i >= 12));
      chk("fill_ae",    32'(ALMOST_EMPTY), 32'(i <= 2));
      chk("fill_full",  32'(FULL), 32'(i == 16));
    end

    // Drain in order.
    for (int i = 1; i <= 16; i++) begin
      pop("drain_data", 32'(i));
      chk("drain_count", 32'(COUNT), 32'(16 - i));
    end
    chk("drain_empty", 32'(EMPTY), 32'd1);

    // Overflow: write to a full FIFO is dropped and flagged.
    for (int i = 0; i < 16; i++) push(32'h20 + 32'(i));
    push(32'hAAAA5555);
    chk("ovf_flag",  32'(OVERFLOW), 32'd1);
    chk("ovf_count", 32'(COUNT), 32'd16);
    for (int i = 0; i < 16; i++) pop("ovf_drain", 32'h20 + 32'(i));
    chk("ovf_sticky", 32'(OVERFLOW), 32'd1);
    ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
    chk("ovf_clr", 32'(OVERFLOW), 32'd0);

    // Underflow with simultaneous write on an empty FIFO.
    RD_EN = 1'b1; WR_EN = 1'b1; WR_DATA = 32'h12345678;
    tick();
    idle();
    chk("unf_flag",  32'(UNDERFLOW), 32'd1);
    chk("unf_count", 32'(COUNT), 32'd1);
`ifndef I2C_TX_FIFO_FWFT_EN
    chk("unf_rdata_hold", RD_DATA, 32'h2F);
`endif
    pop("unf_read", 32'h12345678);
    chk("unf_empty", 32'(EMPTY), 32'd1);

    // Clear and new underflow on the same edge: set wins.
    RD_EN = 1'b1; ERR_CLR = 1'b1;
    tick();
    idle();
    chk("unf_set_wins", 32'(UNDERFLOW), 32'd1);
    ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
    chk("unf_clr", 32'(UNDERFLOW), 32'd0);

    // Full with simultaneous read and write: both accepted, write lands in freed slot.
    for (int i = 0; i < 16; i++) push(32'h100 + 32'(i));
    RD_EN = 1'b1; WR_EN = 1'b1; WR_DATA = 32'h200;
`ifdef I2C_TX_FIFO_FWFT_EN
    chk("rw_full_rdata", RD_DATA, 32'h100);
    tick();
`else
    tick();
    chk("rw_full_rdata", RD_DATA, 32'h100);
`endif
    idle();
    chk("rw_full_count", 32'(COUNT), 32'd16);
    chk("rw_full_ovf",   32'(OVERFLOW), 32'd0);
    for (int i = 1; i < 16; i++) pop("rw_drain", 32'h100 + 32'(i));
    pop("rw_wrap", 32'h200);
    chk("rw_empty", 32'(EMPTY), 32'd1);

    // Reset mid-burst discards stored words.
    push(32'h1); push(32'h2); push(32'h3);
    chk("burst_count", 32'(COUNT), 32'd3);
    PRESET = 1'b1; tick(); PRESET = 1'b0;
    chk("burst_rst_count", 32'(COUNT), 32'd0);
    chk("burst_rst_empty", 32'(EMPTY), 32'd1);
    chk("burst_rst_rdata", RD_DATA, 32'h0);

`ifdef I2C_TX_FIFO_FWFT_EN
    // Fall-through: word visible without a read, acknowledge empties.
    push(32'hCAFEF00D);
    chk("fwft_visible", RD_DATA, 32'hCAFEF00D);
    RD_EN = 1'b1; tick(); RD_EN = 1'b0;
    chk("fwft_empty", 32'(EMPTY), 32'd1);
    chk("fwft_zero",  RD_DATA, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
